// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: integer execute unit for RV base ALU ops plus the M-extension.
// Base ops, multiplies and the divide corner cases answer one cycle after accept.
// Regular divides and remainders use a restoring divider that retires one quotient bit per cycle.
// Results are returned over a valid/ready handshake.
// Optional feature macro: RV_MUL_EN adds MUL/MULH/MULHSU/MULHU. Without it these encodings are illegal.
// XLEN is expected to be 32 or 64.
module alu_muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        RESP
    } state_t;

    state_t state, state_n;

    logic            accept;
    logic            is_op;
    logic            is_imm;
    logic [XLEN-1:0] dec_result;
    logic            dec_illegal;
    logic            dec_div;
    logic [SHAMT_W-1:0] shamt;

    logic [XLEN-1:0] result_q;
    logic            illegal_q;

    // Divider state: quotient register starts as the dividend magnitude and shifts bits out.
    logic [XLEN-1:0] div_quo_q;
    logic [XLEN-1:0] div_rem_q;
    logic [XLEN-1:0] div_dsr_q;
    logic [CNT_W-1:0] div_cnt_q;
    logic            div_neg_q;
    logic            div_neg_r;
    logic            div_is_rem;

    logic            div_signed;
    logic [XLEN-1:0] div_abs_a;
    logic [XLEN-1:0] div_abs_b;
    logic [XLEN:0]   div_shifted;
    logic [XLEN:0]   div_diff;
    logic            div_sub_ok;
    logic [XLEN-1:0] div_quo_next;
    logic [XLEN-1:0] div_rem_next;
    logic [XLEN-1:0] div_final;
    logic            div_last;

`ifdef RV_MUL_EN
    // Operands are extended to 2*XLEN, so the low 2*XLEN bits of each product are exact.
    logic [2*XLEN-1:0] mul_a_s;
    logic [2*XLEN-1:0] mul_a_u;
    logic [2*XLEN-1:0] mul_b_s;
    logic [2*XLEN-1:0] mul_b_u;
    logic [2*XLEN-1:0] prod_ss;
    logic [2*XLEN-1:0] prod_su;
    logic [2*XLEN-1:0] prod_uu;

    assign mul_a_s = {{XLEN{op_a[XLEN-1]}}, op_a};
    assign mul_a_u = {{XLEN{1'b0}}, op_a};
    assign mul_b_s = {{XLEN{op_b[XLEN-1]}}, op_b};
    assign mul_b_u = {{XLEN{1'b0}}, op_b};
    assign prod_ss = mul_a_s * mul_b_s;
    assign prod_su = mul_a_s * mul_b_u;
    assign prod_uu = mul_a_u * mul_b_u;
`endif

    assign is_op     = (opcode == OPC_OP);
    assign is_imm    = (opcode == OPC_OP_IMM);
    assign shamt     = op_b[SHAMT_W-1:0];
    assign in_ready  = !flush && ((state == IDLE) || ((state == RESP) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == RESP);
    assign busy      = (state == DIV);
    assign result    = result_q;
    assign illegal   = illegal_q;

    // Decode the request and compute every single-cycle result. Illegal requests leave the result at zero.
    always_comb begin
        dec_result  = '0;
        dec_illegal = 1'b0;
        dec_div     = 1'b0;
        if (!is_op && !is_imm) begin
            dec_illegal = 1'b1;
        end else if (is_op && (funct7 == F7_MULDIV)) begin
            if (funct3[2]) begin
                if (op_b == '0) begin
                    dec_result = funct3[1] ? op_a : '1;
                end else if (!funct3[0] && (op_a == INT_MIN) && (op_b == '1)) begin
                    dec_result = funct3[1] ? '0 : op_a;
                end else begin
                    dec_div = 1'b1;
                end
            end else begin
`ifdef RV_MUL_EN
                case (funct3[1:0])
                    2'b00:   dec_result = prod_ss[XLEN-1:0];
                    2'b01:   dec_result = prod_ss[2*XLEN-1:XLEN];
                    2'b10:   dec_result = prod_su[2*XLEN-1:XLEN];
                    default: dec_result = prod_uu[2*XLEN-1:XLEN];
                endcase
`else
                dec_illegal = 1'b1;
`endif
            end
        end else begin
            case (funct3)
                3'b000: begin
                    if (is_op && (funct7 == F7_ALT)) begin
                        dec_result = op_a - op_b;
                    end else if (is_op && (funct7 != F7_ZERO)) begin
                        dec_illegal = 1'b1;
                    end else begin
                        dec_result = op_a + op_b;
                    end
                end
                3'b001: begin
                    if ((funct7 == F7_ZERO) || (is_imm && (funct7 == F7_ALT))) begin
                        dec_result = op_a << shamt;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                3'b101: begin
                    if (funct7 == F7_ZERO) begin
                        dec_result = op_a >> shamt;
                    end else if (funct7 == F7_ALT) begin
                        dec_result = $unsigned($signed(op_a) >>> shamt);
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: begin
                    if (is_op && (funct7 != F7_ZERO)) begin
                        dec_illegal = 1'b1;
                    end else begin
                        case (funct3)
                            3'b010:  dec_result = ($signed(op_a) < $signed(op_b)) ? XLEN'(1) : '0;
                            3'b011:  dec_result = (op_a < op_b) ? XLEN'(1) : '0;
                            3'b100:  dec_result = op_a ^ op_b;
                            3'b110:  dec_result = op_a | op_b;
                            default: dec_result = op_a & op_b;
                        endcase
                    end
                end
            endcase
        end
    end

    // Divider operand magnitudes plus one restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        div_signed   = !funct3[0];
        div_abs_a    = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
        div_abs_b    = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;
        div_shifted  = {div_rem_q, div_quo_q[XLEN-1]};
        div_diff     = div_shifted - {1'b0, div_dsr_q};
        div_sub_ok   = !div_diff[XLEN];
        div_rem_next = div_sub_ok ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
        div_quo_next = {div_quo_q[XLEN-2:0], div_sub_ok};
        div_last     = (div_cnt_q == CNT_W'(XLEN-1));
        if (div_is_rem) begin
            div_final = div_neg_r ? -div_rem_next : div_rem_next;
        end else begin
            div_final = div_neg_q ? -div_quo_next : div_quo_next;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. Flush overrides everything; RESP can hand straight over to a new request.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = dec_div ? DIV : RESP;
                end
            end
            DIV: begin
                if (div_last) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (accept) begin
                    state_n = dec_div ? DIV : RESP;
                end else if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
        end
    end

    // Result register and divider datapath. Load on accept, then iterate once per DIV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            illegal_q  <= 1'b0;
            div_quo_q  <= '0;
            div_rem_q  <= '0;
            div_dsr_q  <= '0;
            div_cnt_q  <= '0;
            div_neg_q  <= 1'b0;
            div_neg_r  <= 1'b0;
            div_is_rem <= 1'b0;
        end else if (accept) begin
            illegal_q <= dec_illegal;
            if (dec_div) begin
                div_quo_q  <= div_abs_a;
                div_rem_q  <= '0;
                div_dsr_q  <= div_abs_b;
                div_cnt_q  <= '0;
                div_neg_q  <= div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                div_neg_r  <= div_signed && op_a[XLEN-1];
                div_is_rem <= funct3[1];
            end else begin
                result_q <= dec_result;
            end
        end else if ((state == DIV) && !flush) begin
            div_quo_q <= div_quo_next;
            div_rem_q <= div_rem_next;
            div_cnt_q <= div_cnt_q + CNT_W'(1);
            if (div_last) begin
                result_q <= div_final;
            end
        end
    end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised execute unit: decodes opcode/funct3/funct7 (RV base integer plus M-extension), computes the result, and returns it over a valid/ready handshake.
- Sits between the decode stage and writeback.
- Base ops complete in 1 cycle; divide/remainder run as an iterative multi-cycle sequence; multiply is optional.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, 32 or 64.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from op_b.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight op
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request this cycle
- opcode  input  instruction_format_type  OP or OP_IMM from the common package
- funct3  input  3  instruction funct3
- funct7  input  7  instruction funct7 (imm[11:5] for OP_IMM)
- op_a  input  XLEN  rs1 value
- op_b  input  XLEN  rs2 value or sign-extended immediate
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  computed value
- illegal  output  1  qualified by out_valid; request not decodable
- busy  output  1  division iteration in progress

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, illegal=0, busy=0, all internal division registers 0. in_ready=1 after reset.
- States:
  - IDLE: accept a request when in_valid&&in_ready. Base op or MUL goes to RESP with the result registered. DIV* goes to DIV, or to RESP for the special cases.
  - DIV: one quotient bit per cycle, XLEN cycles, then RESP.
  - RESP: out_valid=1, held stable until out_ready. On out_ready, return to IDLE. A new request may be accepted in the same cycle (back-to-back).
- in_ready = (state==IDLE) || (state==RESP && out_ready).
- Decode, funct3 for OP:
  - 000: ADD, or SUB when funct7=0100000
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL when funct7=0000000, SRA when funct7=0100000
  - 110: OR
  - 111: AND
- Decode, OP with funct7=0000001: M-extension.
  - funct3 000-011: MUL, MULH, MULHSU, MULHU
  - funct3 100-111: DIV, DIVU, REM, REMU
- Decode, OP_IMM: funct3=000 is always ADD (funct7 ignored). Shift decode uses funct7 as above. Other funct3 values ignore funct7.
- Illegal requests complete in 1 cycle with illegal=1, result=0:
  - any other funct7 on OP
  - SLLI/SRLI/SRAI with funct7 not in {0000000, 0100000}
  - any opcode other than OP/OP_IMM
- Shifts use op_b[SHAMT_W-1:0] only. SRA sign-fills. SLT is signed compare; SLTU is unsigned compare. Result is 0 or 1, zero-extended.
- Latency, accept to out_valid:
  - base/MUL/illegal: 1 cycle
  - normal DIV*: XLEN+1 cycles
- Division: restoring, on magnitudes. Signed ops negate the quotient if signs differ; the remainder takes the sign of the dividend.
- Divide by zero (1 cycle, no DIV state):
  - quotient = all ones
  - remainder = op_a
- Signed overflow, op_a = -2^(XLEN-1) and op_b = -1 (1 cycle):
  - quotient = op_a
  - remainder = 0
- busy=1 exactly during the DIV state.
- flush: has priority over every other event. Next cycle: state=IDLE, out_valid=0, busy=0. A request presented in the flush cycle is not accepted (in_ready forced 0 while flush=1).
- Asynchronous reset mid-division: immediate return to the reset values; no partial result is ever emitted.

Optional Feature:
- RV_MUL_EN defined: MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned 2·XLEN-bit product. All have 1-cycle latency and use a registered combinational multiplier.
- RV_MUL_EN undefined: funct7=0000001 with funct3 000-011 is illegal (illegal=1, result=0, 1 cycle). Division is unaffected.

Test Plan:
- Reset release, then OP ADD with a=5, b=7 -> out_valid the next cycle, result=12, illegal=0. Then SUB (funct7=0100000) with a=5, b=7 -> result=0xFFFFFFFE.
- OP SRA with a=0x80000010, b=0x24 (shamt 4) -> 0xF8000001. SRL with the same inputs -> 0x08000001. SLTU with a=1, b=0xFFFFFFFF -> 1. SLT with the same inputs -> 0.
- DIV with a=-7, b=2 -> busy for 32 cycles, out_valid at accept+33, result=-3. REM with a=-7, b=2 -> result=-1.
- DIVU with a=9, b=0 -> 1-cycle response, result=0xFFFFFFFF. DIV with a=0x80000000, b=-1 -> result=0x80000000. REM with a=0x80000000, b=-1 -> result=0.
- out_ready held 0 for 5 cycles on an ADD result -> result stable, in_ready=0. Releasing out_ready with a queued XOR (a=0xF0, b=0xFF) -> back-to-back accept, next result=0x0F.
- flush asserted at DIV cycle 10 -> no out_valid, busy=0 the next cycle. Build without RV_MUL_EN: MULHU -> illegal=1, result=0. Build with RV_MUL_EN: MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE.
